// File: rtl/xor_share_arbiter.sv
// xor_share_arbiter
//
// Several requesters share one bit-serial XOR engine. A round-robin arbiter
// picks one pending request, captures that requester's operands, and the
// engine then produces op_a ^ op_b one bit per cycle, LSB first, through a
// single 1-bit XOR built only from NOR gates. The finished word is published
// on result together with the requester index when done pulses.
//
// Ports
//   clock    in   rising-edge clock
//   reset    in   asynchronous, active-high
//   req      in   [N_REQ]        one request bit per requester, held until granted
//   op_a     in   [N_REQ*WIDTH]  operand A, requester i in bits [i*WIDTH +: WIDTH]
//   op_b     in   [N_REQ*WIDTH]  operand B, same slicing as op_a
//   grant    out  [N_REQ]        one-hot, one cycle: operands of that requester captured
//   busy     out                 high while in SHIFT or DONE
//   result   out  [WIDTH]        XOR of the last completed operation (held)
//   done     out                 one-cycle pulse, result/done_id valid
//   done_id  out  [clog2(N_REQ)] requester index belonging to result
//
// Timing: req sampled at edge T -> grant in cycle T+1, done in cycle
// T+WIDTH+1, earliest next grant in cycle T+WIDTH+3. WIDTH must be >= 2.

module xor_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [N_REQ-1:0]                         req,
    input  logic [N_REQ*WIDTH-1:0]                   op_a,
    input  logic [N_REQ*WIDTH-1:0]                   op_b,
    output logic [N_REQ-1:0]                         grant,
    output logic                                     busy,
    output logic [WIDTH-1:0]                         result,
    output logic                                     done,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] done_id
);

    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sr;          // captured operand A, shifted right each SHIFT cycle
    logic [WIDTH-1:0] b_sr;          // captured operand B, shifted right each SHIFT cycle
    logic [WIDTH-2:0] res_sr;        // result bits computed so far, entering at the top
    logic [CNT_W-1:0] bit_cnt;
    logic [ID_W-1:0]  cur_id;        // requester being served
    logic [ID_W-1:0]  last_granted;
    logic [N_REQ-1:0] grant_q;
    logic [WIDTH-1:0] result_q;
    logic [ID_W-1:0]  done_id_q;

    logic             sel_found;
    logic [ID_W-1:0]  sel_id;
    logic             last_bit;

    // ------------------------------------------------------------------
    // Round-robin search: start just after the last grant and wrap.
    // NOTE: every signal driven from always_comb gets a default at the top
    // of the block so no path leaves it unassigned, which would infer a latch.
    // ------------------------------------------------------------------
    always_comb begin : rr_search
        int idx;
        sel_found = 1'b0;
        sel_id    = '0;
        idx       = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_granted) + i) % N_REQ;
            if (!sel_found && req[idx]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared 1-bit XOR from four NOR levels:
    //   n1 = ~(a|b); n2 = ~a&b; n3 = a&~b; xnor = ~(n2|n3); xor = ~(xnor|xnor)
    // ------------------------------------------------------------------
    logic nor_1, nor_2, nor_3, nor_xnor, xor_bit;

    assign nor_1    = ~(a_sr[0] | b_sr[0]);
    assign nor_2    = ~(a_sr[0] | nor_1);
    assign nor_3    = ~(b_sr[0] | nor_1);
    assign nor_xnor = ~(nor_2 | nor_3);
    assign xor_bit  = ~(nor_xnor | nor_xnor);

    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values, independent of statement order.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (sel_found) state_next = ST_SHIFT;
            ST_SHIFT: if (last_bit)  state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: capture, bit-serial shift, publish on entry to DONE.
    // result_q only changes on the SHIFT->DONE edge, so it is stable
    // while the next word is being assembled in res_sr.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_sr         <= '0;
            b_sr         <= '0;
            res_sr       <= '0;
            bit_cnt      <= '0;
            cur_id       <= '0;
            last_granted <= ID_W'(N_REQ - 1);
            grant_q      <= '0;
            result_q     <= '0;
            done_id_q    <= '0;
        end else begin
            grant_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        a_sr         <= op_a[int'(sel_id)*WIDTH +: WIDTH];
                        b_sr         <= op_b[int'(sel_id)*WIDTH +: WIDTH];
                        bit_cnt      <= '0;
                        cur_id       <= sel_id;
                        last_granted <= sel_id;
                        grant_q      <= N_REQ'(1) << sel_id;
                    end
                end
                ST_SHIFT: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    res_sr  <= (WIDTH-1)'({xor_bit, res_sr} >> 1);
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (last_bit) begin
                        result_q  <= {xor_bit, res_sr};
                        done_id_q <= cur_id;
                        bit_cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant   = grant_q;
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);
    assign result  = result_q;
    assign done_id = done_id_q;

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Directed testbench for xor_share_arbiter (N_REQ=4, WIDTH=8).
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge, half a cycle away from the active rising edge.

module tb_xor_share_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;

    logic                   clock;
    logic                   reset;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] op_a;
    logic [N_REQ*WIDTH-1:0] op_b;
    logic [N_REQ-1:0]       grant;
    logic                   busy;
    logic [WIDTH-1:0]       result;
    logic                   done;
    logic [1:0]             done_id;

    int vectors     = 0;
    int miscompares = 0;

    logic       mon_en   = 1'b0;
    logic [3:0] mon_mask = 4'b0000;
    logic       stray    = 1'b0;

    xor_share_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .op_a    (op_a),
        .op_b    (op_b),
        .grant   (grant),
        .busy    (busy),
        .result  (result),
        .done    (done),
        .done_id (done_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Flags any grant bit outside the allowed mask while enabled.
    always @(negedge clock) begin
        if (mon_en && ((grant & ~mon_mask) != 4'b0000)) stray = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        op_a[i*WIDTH +: WIDTH] = a;
        op_b[i*WIDTH +: WIDTH] = b;
    endtask

    // Returns number of falling edges until grant != 0 (max+1 on timeout).
    task automatic wait_grant(input int max, output int cycles);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (grant == 4'b0000 && cycles <= max);
    endtask

    // Returns number of falling edges until done (max+1 on timeout).
    task automatic wait_done(input int max, output int cycles);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (!done && cycles <= max);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req   = '0;
        op_a  = '0;
        op_b  = '0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = '0;
        op_a  = '0;
        op_b  = '0;
        #1;
        vectors++;
        if ({grant, busy, done, result, done_id} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got grant=%b busy=%b done=%b result=%h id=%0d, expected all 0",
                     grant, busy, done, result, done_id);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if ({grant, busy, done, result, done_id} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_idle: got grant=%b busy=%b done=%b result=%h id=%0d, expected all 0",
                     grant, busy, done, result, done_id);
        end
    endtask

    task automatic test_single_op();
        int  c;
        logic bad;
        do_reset();
        set_ops(0, 8'hA5, 8'h0F);
        req = 4'b0001;
        wait_grant(20, c);
        vectors++;
        if (c !== 1 || grant !== 4'b0001 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_grant: got cycles=%0d grant=%b busy=%b, expected 1 0001 1", c, grant, busy);
        end
        req = 4'b0000;
        bad = 1'b0;
        for (int k = 2; k <= WIDTH; k++) begin
            @(negedge clock);
            if (done !== 1'b0 || result !== 8'h00 || grant !== 4'b0000) bad = 1'b1;
        end
        vectors++;
        if (bad !== 1'b0) begin
            miscompares++;
            $display("FAIL single_shift_quiet: got early done/result/grant activity, expected none");
        end
        @(negedge clock);
        vectors++;
        if (done !== 1'b1 || result !== 8'hAA || done_id !== 2'd0) begin
            miscompares++;
            $display("FAIL single_done: got done=%b result=%h id=%0d, expected 1 aa 0", done, result, done_id);
        end
        @(negedge clock);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 8'hAA || grant !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_after: got done=%b busy=%b result=%h grant=%b, expected 0 0 aa 0000",
                     done, busy, result, grant);
        end
    endtask

    task automatic test_round_robin();
        int c;
        int exp_id;
        logic [7:0] exp_res [4] = '{8'hE2, 8'h3B, 8'hFC, 8'h2D};
        do_reset();
        set_ops(0, 8'h12, 8'hF0);
        set_ops(1, 8'h34, 8'h0F);
        set_ops(2, 8'h56, 8'hAA);
        set_ops(3, 8'h78, 8'h55);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_id = n % 4;
            wait_grant(20, c);
            vectors++;
            if (c !== ((n == 0) ? 1 : 2) || grant !== (4'b0001 << exp_id)) begin
                miscompares++;
                $display("FAIL rr_grant_%0d: got cycles=%0d grant=%b, expected %0d %b",
                         n, c, grant, (n == 0) ? 1 : 2, 4'b0001 << exp_id);
            end
            wait_done(20, c);
            vectors++;
            if (c !== WIDTH || done_id !== exp_id[1:0] || result !== exp_res[exp_id]) begin
                miscompares++;
                $display("FAIL rr_done_%0d: got cycles=%0d id=%0d result=%h, expected %0d %0d %h",
                         n, c, done_id, result, WIDTH, exp_id, exp_res[exp_id]);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_alternate();
        int c;
        int exp_id;
        do_reset();
        set_ops(0, 8'hC0, 8'h0C);
        set_ops(2, 8'h33, 8'h11);
        mon_mask = 4'b0101;
        stray    = 1'b0;
        mon_en   = 1'b1;
        req = 4'b0101;
        for (int n = 0; n < 4; n++) begin
            exp_id = (n % 2 == 0) ? 0 : 2;
            wait_grant(20, c);
            vectors++;
            if (grant !== (4'b0001 << exp_id)) begin
                miscompares++;
                $display("FAIL alt_grant_%0d: got %b, expected %b", n, grant, 4'b0001 << exp_id);
            end
            wait_done(20, c);
            vectors++;
            if (done_id !== exp_id[1:0] || result !== ((exp_id == 0) ? 8'hCC : 8'h22)) begin
                miscompares++;
                $display("FAIL alt_done_%0d: got id=%0d result=%h, expected %0d %h",
                         n, done_id, result, exp_id, (exp_id == 0) ? 8'hCC : 8'h22);
            end
        end
        req = 4'b0000;
        @(negedge clock);
        @(negedge clock);
        mon_en = 1'b0;
        vectors++;
        if (stray !== 1'b0) begin
            miscompares++;
            $display("FAIL alt_stray_grant: got a grant outside 0101, expected none");
        end
    endtask

    task automatic test_edge_values();
        int   c;
        logic bad;
        do_reset();
        set_ops(0, 8'h3C, 8'h3C);
        set_ops(1, 8'hFF, 8'h00);
        req = 4'b0001;
        wait_grant(20, c);
        req = 4'b0000;
        wait_done(20, c);
        vectors++;
        if (c !== WIDTH || result !== 8'h00 || done_id !== 2'd0) begin
            miscompares++;
            $display("FAIL edge_equal: got cycles=%0d result=%h id=%0d, expected %0d 00 0", c, result, done_id, WIDTH);
        end
        req = 4'b0010;
        wait_grant(20, c);
        vectors++;
        if (c !== 2 || grant !== 4'b0010) begin
            miscompares++;
            $display("FAIL edge_grant1: got cycles=%0d grant=%b, expected 2 0010", c, grant);
        end
        req = 4'b0000;
        bad = 1'b0;
        c   = 0;
        do begin
            @(negedge clock);
            c++;
            if (!done && (result !== 8'h00 || done_id !== 2'd0)) bad = 1'b1;
        end while (!done && c <= 20);
        vectors++;
        if (c !== WIDTH || bad !== 1'b0 || result !== 8'hFF || done_id !== 2'd1) begin
            miscompares++;
            $display("FAIL edge_ones: got cycles=%0d unstable=%b result=%h id=%0d, expected %0d 0 ff 1",
                     c, bad, result, done_id, WIDTH);
        end
        repeat (3) @(negedge clock);
        vectors++;
        if (result !== 8'hFF || done_id !== 2'd1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL edge_hold: got result=%h id=%0d done=%b, expected ff 1 0", result, done_id, done);
        end
    endtask

    // Runs right after test_edge_values so result/done_id are non-zero.
    task automatic test_reset_mid_shift();
        int   c;
        logic seen;
        set_ops(1, 8'h81, 8'h42);
        req = 4'b0010;
        wait_grant(20, c);
        vectors++;
        if (c !== 1 || grant !== 4'b0010) begin
            miscompares++;
            $display("FAIL mid_grant: got cycles=%0d grant=%b, expected 1 0010", c, grant);
        end
        req = 4'b0000;
        repeat (3) @(negedge clock);
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_busy: got busy=%b done=%b, expected 1 0", busy, done);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({grant, busy, done, result, done_id} !== 15'd0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got grant=%b busy=%b done=%b result=%h id=%0d, expected all 0",
                     grant, busy, done, result, done_id);
        end
        @(negedge clock);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (15) begin
            @(negedge clock);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_no_done: got done/busy after abort, expected none");
        end
        req = 4'b0010;
        wait_grant(20, c);
        vectors++;
        if (c !== 1 || grant !== 4'b0010) begin
            miscompares++;
            $display("FAIL mid_regrant: got cycles=%0d grant=%b, expected 1 0010", c, grant);
        end
        req = 4'b0000;
        wait_done(20, c);
        vectors++;
        if (c !== WIDTH || result !== 8'hC3 || done_id !== 2'd1) begin
            miscompares++;
            $display("FAIL mid_result: got cycles=%0d result=%h id=%0d, expected %0d c3 1", c, result, done_id, WIDTH);
        end
    endtask

    task automatic test_req_drop();
        int c;
        do_reset();
        set_ops(2, 8'h5A, 8'hC3);
        req = 4'b0100;
        wait_grant(20, c);
        vectors++;
        if (c !== 1 || grant !== 4'b0100) begin
            miscompares++;
            $display("FAIL drop_grant: got cycles=%0d grant=%b, expected 1 0100", c, grant);
        end
        req = 4'b0000;
        set_ops(2, 8'h00, 8'hFF);
        @(negedge clock);
        set_ops(2, 8'hF0, 8'h0F);
        req = 4'b1000;
        wait_done(20, c);
        vectors++;
        if (c !== WIDTH - 1 || result !== 8'h99 || done_id !== 2'd2) begin
            miscompares++;
            $display("FAIL drop_result: got cycles=%0d result=%h id=%0d, expected %0d 99 2",
                     c, result, done_id, WIDTH - 1);
        end
        req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_alternate();
        test_edge_values();
        test_reset_mid_shift();
        test_req_drop();
        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/xor_share_arbiter.md
XOR_SHARE_ARBITER -- requirements
Module: xor_share_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing the XOR unit.
REQ-002 Parameter WIDTH, default 8, SHALL set the operand width in bits.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous and active-high.
REQ-005 req  input  N_REQ  SHALL carry one request bit per requester, held until granted.
REQ-006 op_a  input  N_REQ*WIDTH  SHALL carry operand A per requester; slice i = bits [i*WIDTH +: WIDTH].
REQ-007 op_b  input  N_REQ*WIDTH  SHALL carry operand B per requester, same slicing as op_a.
REQ-008 grant  output  N_REQ  SHALL be a one-hot, one-cycle acknowledge that the requester's operands were captured.
REQ-009 busy  output  1  SHALL be high while an operation is in progress (SHIFT or DONE state).
REQ-010 result  output  WIDTH  SHALL carry op_a XOR op_b of the last completed operation.
REQ-011 done  output  1  SHALL be a one-cycle pulse marking result valid.
REQ-012 done_id  output  clog2(N_REQ)  SHALL carry the index of the requester whose result is on result.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-014 IDLE: if any req bit is high at edge T, the block SHALL select one requester, capture its op_a/op_b into internal shift registers, and enter SHIFT; otherwise it SHALL remain in IDLE.
REQ-015 Selection SHALL be round-robin: search starts at (last_granted+1) mod N_REQ, ascending with wrap-around.
REQ-016 grant SHALL be high for exactly the cycle following edge T, one-hot on the selected index; it SHALL be zero at all other times.
REQ-017 SHIFT SHALL last exactly WIDTH cycles, computing one result bit per cycle, LSB first, through a single shared 1-bit XOR built only from NOR gates.
REQ-018 A bit counter SHALL count 0..WIDTH-1 in SHIFT; on the count of WIDTH-1 the FSM SHALL enter DONE.
REQ-019 DONE SHALL last one cycle: done=1, result and done_id valid; the next state SHALL be IDLE.
REQ-020 Latency: req sampled at edge T -> done high in cycle T+WIDTH+1; next grant no earlier than cycle T+WIDTH+3.
REQ-021 result and done_id SHALL hold their values after DONE until the next DONE or reset.
REQ-022 result SHALL NOT change during SHIFT; bits SHALL be assembled internally and transferred on entry to DONE.
REQ-023 req changes during SHIFT/DONE SHALL be ignored; operands are sampled only at the capture edge.
REQ-024 A requester whose req stays high after its grant SHALL be treated as a new request in the next IDLE cycle.
REQ-025 Simultaneous requests SHALL be served one per operation in round-robin order; none SHALL be starved.

Reset
REQ-026 On reset: state=IDLE, grant=0, busy=0, done=0, result=0, done_id=0, bit counter=0, last_granted=N_REQ-1 (requester 0 has first priority).
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL abort the operation immediately; no done pulse SHALL be produced for it.

Verification
REQ-028 req=0001, op_a[0]=0xA5, op_b[0]=0x0F at edge T -> grant=0001 in cycle T+1; done=1, result=0xAA, done_id=0 in cycle T+9.
REQ-029 req=1111 held, requesters' operands distinct -> grants in order 0,1,2,3,0; each done_id matches its grant and result matches its XOR.
REQ-030 req[0] and req[2] held continuously -> grants alternate 0,2,0,2; no other grant bit ever asserts.
REQ-031 op_a=0xFF/op_b=0x00 -> result 0xFF; op_a=op_b=0x3C -> result 0x00; result stable between done pulses.
REQ-032 Reset asserted at fourth SHIFT cycle -> all outputs 0 within the same cycle; no done afterward; next req=0010 granted normally.
REQ-033 req dropped in cycle T+1 with operands changed during SHIFT -> result reflects operands captured at edge T.
